dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, word-address bits; depth = 2**ADDR_W words of 32 bits.
REQ-002 SHALL have parameter READ_LAT, default 1, read latency in cycles, legal range 1..4.
REQ-003 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when valid&ready.
REQ-007 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-008 SHALL have port req_size, input, 2, 00 byte / 01 half / 10 word / 11 reserved=word.
REQ-009 SHALL have port req_unsigned, input, 1, load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr, input, ADDR_W+2, byte address.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, misaligned-access flag, qualified by rsp_valid.

Function
REQ-015 SHALL run FSM IDLE -> BUSY -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-016 SHALL latch we/size/unsigned/addr/wdata on acceptance; one request outstanding at a time.
REQ-017 Load accepted at cycle T SHALL give rsp_valid at T+READ_LAT (READ_LAT=1 skips BUSY; else BUSY counts READ_LAT-1 cycles).
REQ-018 Store accepted at T SHALL update memory at the T+1 edge and pulse rsp_valid at T+1, independent of READ_LAT.
REQ-019 Byte lanes SHALL be big-endian: byte offset 0 = bits[31:24], half offset 0 = bits[31:16].
REQ-020 Byte/half stores SHALL modify only the addressed lanes; other lanes keep their value.
REQ-021 Loads SHALL extract the addressed lane and sign/zero-extend per req_unsigned; word loads ignore req_unsigned.
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 req_valid in non-IDLE states SHALL be ignored; no queueing.
REQ-024 rsp_valid SHALL be exactly one cycle; no back-pressure on the response.

Reset
REQ-025 With rst_n=0 at an edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, word i initialised to i+1.
REQ-026 Reset mid-operation SHALL abort the request: no response, no memory write.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: misaligned request completes at normal latency with rsp_err=1, rsp_rdata=0, no memory write.
REQ-028 Macro undefined: misaligned low address bits are forced to zero (aligned access) and rsp_err is tied 0.

Structure
REQ-029 Package dmem_pkg SHALL hold the size encoding constants, the FSM state typedef and the READ_LAT bounds.
REQ-030 Combinational sub-module dmem_align SHALL perform store lane merge and load extract/extend; dmem_ctrl holds FSM, latency counter and storage.

Verification
REQ-031 After reset, LW addr 0x08, READ_LAT=1 -> rsp_valid next cycle, rdata=0x00000003, err=0.
REQ-032 SB 0xAB to addr 0x05, then LW 0x04 -> 0x00AB0002; LB 0x05 -> 0xFFFFFFAB; LBU 0x05 -> 0x000000AB.
REQ-033 READ_LAT=3, LH 0x02 after SW 0x1234ABCD to 0x00 -> rsp_valid exactly 3 cycles after accept, rdata=0xFFFFABCD; req_ready low throughout.
REQ-034 LW addr 0x06: with DMEM_MISALIGN_TRAP_EN -> err=1, rdata=0; without -> err=0, rdata=0x00000002.
REQ-035 SW to 0x0C then rst_n=0 during BUSY of a following load -> no rsp_valid, next-cycle req_ready=1, LW 0x0C returns 0x00000004.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and helpers for the dmem_ctrl data-memory controller.
package dmem_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 4;
    localparam int unsigned CNT_W        = 2;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Reserved size encoding behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == SIZE_RSV) ? SIZE_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && off[0]) || ((size == SIZE_W) && (off != 2'b00));
    endfunction

    // Clears the low offset bits that a half or word access must not use.
    function automatic logic [1:0] aligned_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] res;
        case (size)
            SIZE_B:  res = off;
            SIZE_H:  res = {off[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Big-endian byte-lane logic: store merge into an existing word and load extract/extend.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        off_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] st_word_o,
    output logic [DATA_W-1:0] ld_data_o
);

    // Offset 0 is the most significant lane, so the lane LSB is (3 - off) * 8.
    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_lsb = {~off_i, 3'b000};
        half_lsb = {~off_i[1], 4'b0000};
        byte_v   = word_i[byte_lsb +: 8];
        half_v   = word_i[half_lsb +: 16];
    end

    always_comb begin
        st_word_o = word_i;
        case (size_i)
            SIZE_B:  st_word_o[byte_lsb +: 8]  = wdata_i[7:0];
            SIZE_H:  st_word_o[half_lsb +: 16] = wdata_i[15:0];
            default: st_word_o = wdata_i;
        endcase
    end

    always_comb begin
        ld_data_o = word_i;
        case (size_i)
            SIZE_B:  ld_data_o = unsigned_i ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SIZE_H:  ld_data_o = unsigned_i ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: ld_data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller with configurable read latency.
// DMEM_MISALIGN_TRAP_EN: misaligned accesses report rsp_err instead of being silently aligned.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BA_W  = ADDR_W + 2;
    localparam int unsigned LAT   = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                    (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'((LAT > 1) ? (LAT - 2) : 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [BA_W-1:0]      addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;
    logic                 rsp_err_q;
    logic                 ready_q;

    logic                 accept_c;
    logic                 sel_in_c;
    logic                 eff_we_c;
    logic [1:0]           eff_size_c;
    logic                 eff_uns_c;
    logic [BA_W-1:0]      eff_addr_c;
    logic [DATA_W-1:0]    eff_wdata_c;
    logic [1:0]           off_c;
    logic [ADDR_W-1:0]    word_idx_c;
    logic [DATA_W-1:0]    rd_word_c;
    logic [DATA_W-1:0]    st_word_c;
    logic [DATA_W-1:0]    ld_data_c;
    logic                 err_c;
    logic                 mem_we_c;
    logic                 resp_go_c;
    logic [DATA_W-1:0]    rsp_rdata_d;

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // In IDLE the live request is used so that stores and single-cycle loads finish at the accept edge.
    always_comb begin
        accept_c    = (state_q == ST_IDLE) && req_valid;
        sel_in_c    = (state_q == ST_IDLE);
        eff_we_c    = sel_in_c ? req_we       : we_q;
        eff_size_c  = norm_size(sel_in_c ? req_size : size_q);
        eff_uns_c   = sel_in_c ? req_unsigned : uns_q;
        eff_addr_c  = sel_in_c ? req_addr     : addr_q;
        eff_wdata_c = sel_in_c ? req_wdata    : wdata_q;
        off_c       = aligned_off(eff_size_c, eff_addr_c[1:0]);
        word_idx_c  = eff_addr_c[BA_W-1:2];
        rd_word_c   = mem_q[word_idx_c];
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err_c = is_misaligned(eff_size_c, eff_addr_c[1:0]);
`else
    assign err_c = 1'b0;
`endif

    dmem_align u_align (
        .word_i     (rd_word_c),
        .wdata_i    (eff_wdata_c),
        .size_i     (eff_size_c),
        .off_i      (off_c),
        .unsigned_i (eff_uns_c),
        .st_word_o  (st_word_c),
        .ld_data_o  (ld_data_c)
    );

    // Next-state, latency counter and response generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we_c  = 1'b0;
        resp_go_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_we || (LAT == 1)) begin
                        state_d   = ST_RESP;
                        resp_go_c = 1'b1;
                        mem_we_c  = req_we && !err_c;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = LAT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d   = ST_RESP;
                    resp_go_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rsp_rdata_d = (resp_go_c && !eff_we_c && !err_c) ? ld_data_c : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= SIZE_B;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ready_q     <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i + 1);
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= resp_go_c;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= resp_go_c && err_c;
            ready_q     <= (state_d == ST_IDLE);
            if (accept_c) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (mem_we_c) begin
                mem_q[word_idx_c] <= st_word_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: READ_LAT=1 and READ_LAT=3 instances share one request stream.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;

    logic        a_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(3), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_ctrl #(.ADDR_W(3), .READ_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request to both instances; records first response cycle, pulse count and payload.
    task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [4:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        int a_lat = 0, b_lat = 0, a_cnt = 0, b_cnt = 0;
        logic [31:0] a_d = '0, b_d = '0;
        logic a_e = 1'b0, b_e = 1'b0, b_rdy_bad = 1'b0;
        @(negedge clk);
        check_eq({tag, ".a_rdy"}, 32'(a_ready), 32'd1);
        check_eq({tag, ".b_rdy"}, 32'(b_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) req_valid = 1'b0;
            if (a_rsp_valid) begin
                a_cnt++;
                if (a_lat == 0) begin a_lat = cyc; a_d = a_rsp_rdata; a_e = a_rsp_err; end
            end
            if (b_rsp_valid) begin
                b_cnt++;
                if (b_lat == 0) begin b_lat = cyc; b_d = b_rsp_rdata; b_e = b_rsp_err; end
            end
            if (b_ready && (b_lat == 0 || b_lat == cyc)) b_rdy_bad = 1'b1;
        end
        check_eq({tag, ".a_lat"}, 32'(a_lat), 32'd1);
        check_eq({tag, ".b_lat"}, 32'(b_lat), we ? 32'd1 : 32'd3);
        check_eq({tag, ".a_pulses"}, 32'(a_cnt), 32'd1);
        check_eq({tag, ".b_pulses"}, 32'(b_cnt), 32'd1);
        check_eq({tag, ".a_rdata"}, a_d, exp_d);
        check_eq({tag, ".b_rdata"}, b_d, exp_d);
        check_eq({tag, ".a_err"}, 32'(a_e), 32'(exp_e));
        check_eq({tag, ".b_err"}, 32'(b_e), 32'(exp_e));
        check_eq({tag, ".b_rdy_busy"}, 32'(b_rdy_bad), 32'd0);
    endtask

    initial begin
        int stray;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst.a_ready", 32'(a_ready), 32'd1);
        check_eq("rst.b_ready", 32'(b_ready), 32'd1);
        check_eq("rst.a_valid", 32'(a_rsp_valid), 32'd0);
        check_eq("rst.b_valid", 32'(b_rsp_valid), 32'd0);
        check_eq("rst.a_rdata", a_rsp_rdata, 32'd0);
        check_eq("rst.b_err", 32'(b_rsp_err), 32'd0);

        xact("lw08", 1'b0, 2'b10, 1'b0, 5'h08, '0, 32'h0000_0003, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        xact("lw06_mis", 1'b0, 2'b10, 1'b0, 5'h06, '0, 32'h0000_0000, 1'b1);
`else
        xact("lw06_mis", 1'b0, 2'b10, 1'b0, 5'h06, '0, 32'h0000_0002, 1'b0);
`endif
        xact("sb05", 1'b1, 2'b00, 1'b0, 5'h05, 32'h0000_00AB, 32'h0, 1'b0);
        xact("lw04", 1'b0, 2'b10, 1'b0, 5'h04, '0, 32'h00AB_0002, 1'b0);
        xact("lb05", 1'b0, 2'b00, 1'b0, 5'h05, '0, 32'hFFFF_FFAB, 1'b0);
        xact("lbu05", 1'b0, 2'b00, 1'b1, 5'h05, '0, 32'h0000_00AB, 1'b0);
        xact("sw00", 1'b1, 2'b10, 1'b0, 5'h00, 32'h1234_ABCD, 32'h0, 1'b0);
        xact("lh02", 1'b0, 2'b01, 1'b0, 5'h02, '0, 32'hFFFF_ABCD, 1'b0);
        xact("lhu02", 1'b0, 2'b01, 1'b1, 5'h02, '0, 32'h0000_ABCD, 1'b0);
        xact("lb00", 1'b0, 2'b00, 1'b0, 5'h00, '0, 32'h0000_0012, 1'b0);
        xact("lb03", 1'b0, 2'b00, 1'b0, 5'h03, '0, 32'hFFFF_FFCD, 1'b0);
        xact("sh06", 1'b1, 2'b01, 1'b0, 5'h06, 32'h0000_8765, 32'h0, 1'b0);
        xact("lw04b", 1'b0, 2'b10, 1'b1, 5'h04, '0, 32'h00AB_8765, 1'b0);
        xact("lrsv04", 1'b0, 2'b11, 1'b0, 5'h04, '0, 32'h00AB_8765, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        xact("sh03_mis", 1'b1, 2'b01, 1'b0, 5'h03, 32'h0000_FFFF, 32'h0, 1'b1);
        xact("lw00_chk", 1'b0, 2'b10, 1'b0, 5'h00, '0, 32'h1234_ABCD, 1'b0);
`else
        xact("sh03_mis", 1'b1, 2'b01, 1'b0, 5'h03, 32'h0000_FFFF, 32'h0, 1'b0);
        xact("lw00_chk", 1'b0, 2'b10, 1'b0, 5'h00, '0, 32'h1234_FFFF, 1'b0);
`endif
        xact("sw0c", 1'b1, 2'b10, 1'b0, 5'h0C, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("lw0c", 1'b0, 2'b10, 1'b0, 5'h0C, '0, 32'hDEAD_BEEF, 1'b0);

        // Reset the READ_LAT=3 instance while its load is in BUSY.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 5'h0C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        check_eq("abort.busy_valid", 32'(b_rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort.b_ready", 32'(b_ready), 32'd1);
        check_eq("abort.a_ready", 32'(a_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (b_rsp_valid) stray++;
            @(negedge clk);
        end
        check_eq("abort.no_rsp", 32'(stray), 32'd0);
        xact("lw0c_rst", 1'b0, 2'b10, 1'b0, 5'h0C, '0, 32'h0000_0004, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
